// File: rtl/exu_stage.sv
// Execute stage: one EX slot feeding a WB slot. The ALU runs
// combinationally on the EX slot. Taken branches, JAL and JALR send a
// one-cycle redirect to fetch when the uop leaves EX. The shared types
// (liang_pkg) and the ALU are defined in this file so it builds alone.

package liang_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_BRANCH = 3'd1,
    FU_JAL    = 3'd2,
    FU_JALR   = 3'd3,
    FU_LOAD   = 3'd4,
    FU_STORE  = 3'd5
  } fu_op_e;

  typedef logic [3:0] fu_func_t;

  // ALU functions (used when fu_op == FU_ALU)
  localparam fu_func_t ALU_ADD  = 4'd0;
  localparam fu_func_t ALU_SUB  = 4'd1;
  localparam fu_func_t ALU_SLL  = 4'd2;
  localparam fu_func_t ALU_SLT  = 4'd3;
  localparam fu_func_t ALU_SLTU = 4'd4;
  localparam fu_func_t ALU_XOR  = 4'd5;
  localparam fu_func_t ALU_SRL  = 4'd6;
  localparam fu_func_t ALU_SRA  = 4'd7;
  localparam fu_func_t ALU_OR   = 4'd8;
  localparam fu_func_t ALU_AND  = 4'd9;

  // Branch conditions (used when fu_op == FU_BRANCH)
  localparam fu_func_t BR_EQ  = 4'd0;
  localparam fu_func_t BR_NE  = 4'd1;
  localparam fu_func_t BR_LT  = 4'd4;
  localparam fu_func_t BR_GE  = 4'd5;
  localparam fu_func_t BR_LTU = 4'd6;
  localparam fu_func_t BR_GEU = 4'd7;

  // use_imm selects imm instead of rs2 as the second ALU operand.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fu_op_e          fu_op;
    fu_func_t        fu_func;
    logic            use_imm;
  } uop_info_t;
endpackage

// Combinational ALU: arithmetic/logic value, link address, memory
// address, and the branch condition.
module liang_alu
  import liang_pkg::*;
(
  input  fu_op_e          fu_op_i,
  input  fu_func_t        fu_func_i,
  input  logic            use_imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] alu_res_o,
  output logic            jump_o
);
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic            cond;

  assign op_b  = use_imm_i ? imm_i : rs2_i;
  assign shamt = op_b[4:0];

  // Result selection by functional unit and function code
  always_comb begin
    alu_res_o = '0;
    case (fu_op_i)
      FU_ALU: begin
        case (fu_func_i)
          ALU_ADD:  alu_res_o = rs1_i + op_b;
          ALU_SUB:  alu_res_o = rs1_i - op_b;
          ALU_SLL:  alu_res_o = rs1_i << shamt;
          ALU_SLT:  alu_res_o = {{(XLEN-1){1'b0}}, $signed(rs1_i) < $signed(op_b)};
          ALU_SLTU: alu_res_o = {{(XLEN-1){1'b0}}, rs1_i < op_b};
          ALU_XOR:  alu_res_o = rs1_i ^ op_b;
          ALU_SRL:  alu_res_o = rs1_i >> shamt;
          ALU_SRA:  alu_res_o = XLEN'($signed(rs1_i) >>> shamt);
          ALU_OR:   alu_res_o = rs1_i | op_b;
          ALU_AND:  alu_res_o = rs1_i & op_b;
          default:  alu_res_o = '0;
        endcase
      end
      FU_JAL, FU_JALR:   alu_res_o = pc_i + XLEN'(4);
      FU_LOAD, FU_STORE: alu_res_o = rs1_i + imm_i;
      default:           alu_res_o = '0;
    endcase
  end

  // Branch condition always compares rs1 against rs2
  always_comb begin
    cond = 1'b0;
    case (fu_func_i)
      BR_EQ:   cond = (rs1_i == rs2_i);
      BR_NE:   cond = (rs1_i != rs2_i);
      BR_LT:   cond = ($signed(rs1_i) < $signed(rs2_i));
      BR_GE:   cond = !($signed(rs1_i) < $signed(rs2_i));
      BR_LTU:  cond = (rs1_i < rs2_i);
      BR_GEU:  cond = !(rs1_i < rs2_i);
      default: cond = 1'b0;
    endcase
  end

  assign jump_o = (fu_op_i == FU_BRANCH) && cond;
endmodule

module exu_stage
  import liang_pkg::*;
#(
  parameter int RF_IDX_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  uop_info_t           id_uop_i,
  input  logic [XLEN-1:0]     id_rs1_i,
  input  logic [XLEN-1:0]     id_rs2_i,
  input  logic [RF_IDX_W-1:0] id_rd_i,
  input  logic                id_rd_wen_i,
  input  logic                flush_i,
  output logic                redirect_valid_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output uop_info_t           wb_uop_o,
  output logic [XLEN-1:0]     wb_res_o,
  output logic [XLEN-1:0]     wb_rs2_o,
  output logic [RF_IDX_W-1:0] wb_rd_o,
  output logic                wb_rd_wen_o
);
  // EX slot
  logic                ex_valid_reg;
  uop_info_t           ex_uop_reg;
  logic [XLEN-1:0]     ex_rs1_reg;
  logic [XLEN-1:0]     ex_rs2_reg;
  logic [RF_IDX_W-1:0] ex_rd_reg;
  logic                ex_rd_wen_reg;

  // WB slot
  logic                wb_valid_reg;
  uop_info_t           wb_uop_reg;
  logic [XLEN-1:0]     wb_res_reg;
  logic [XLEN-1:0]     wb_rs2_reg;
  logic [RF_IDX_W-1:0] wb_rd_reg;
  logic                wb_rd_wen_reg;

  logic            ex_ready;
  logic            ex_fire;
  logic            wb_fire;
  logic            id_fire;
  logic            id_ready;
  logic [XLEN-1:0] alu_res;
  logic            alu_jump;
  logic            cf_taken;
  logic [XLEN-1:0] tgt_base;
  logic [XLEN-1:0] tgt_sum;
  logic [XLEN-1:0] tgt_pc;
  logic            redirect_valid;
  logic            ex_rd_wen_eff;

  liang_alu u_alu (
    .fu_op_i   (ex_uop_reg.fu_op),
    .fu_func_i (ex_uop_reg.fu_func),
    .use_imm_i (ex_uop_reg.use_imm),
    .pc_i      (ex_uop_reg.pc),
    .rs1_i     (ex_rs1_reg),
    .rs2_i     (ex_rs2_reg),
    .imm_i     (ex_uop_reg.imm),
    .alu_res_o (alu_res),
    .jump_o    (alu_jump)
  );

  // Handshakes; rst_ni gating keeps every transfer dead while in reset
  assign ex_ready = !wb_valid_reg || wb_ready_i;
  assign ex_fire  = rst_ni && ex_valid_reg && ex_ready && !flush_i;
  assign wb_fire  = wb_valid_reg && wb_ready_i;

  // Control-flow decision for the uop in EX
  always_comb begin
    cf_taken = 1'b0;
    case (ex_uop_reg.fu_op)
      FU_BRANCH:       cf_taken = alu_jump;
      FU_JAL, FU_JALR: cf_taken = 1'b1;
      default:         cf_taken = 1'b0;
    endcase
  end

  // Dedicated target adder, separate from the ALU; JALR clears bit 0
  assign tgt_base = (ex_uop_reg.fu_op == FU_JALR) ? ex_rs1_reg : ex_uop_reg.pc;
  assign tgt_sum  = tgt_base + ex_uop_reg.imm;
  assign tgt_pc   = (ex_uop_reg.fu_op == FU_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

  // Redirect only on the transfer cycle, so a stalled uop pulses once
  assign redirect_valid = ex_fire && cf_taken;

  // Wrong-path uops offered during redirect/flush are refused
  assign id_ready = rst_ni && !flush_i && !redirect_valid && (!ex_valid_reg || ex_fire);
  assign id_fire  = id_valid_i && id_ready;

  // Branches and stores never write the register file; x0 is never written
  assign ex_rd_wen_eff = ex_rd_wen_reg && (ex_rd_reg != '0)
                         && (ex_uop_reg.fu_op != FU_BRANCH)
                         && (ex_uop_reg.fu_op != FU_STORE);

  // EX slot: flush beats load, load beats drain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_valid_reg  <= 1'b0;
      ex_uop_reg    <= '0;
      ex_rs1_reg    <= '0;
      ex_rs2_reg    <= '0;
      ex_rd_reg     <= '0;
      ex_rd_wen_reg <= 1'b0;
    end else if (flush_i) begin
      ex_valid_reg <= 1'b0;
    end else if (id_fire) begin
      ex_valid_reg  <= 1'b1;
      ex_uop_reg    <= id_uop_i;
      ex_rs1_reg    <= id_rs1_i;
      ex_rs2_reg    <= id_rs2_i;
      ex_rd_reg     <= id_rd_i;
      ex_rd_wen_reg <= id_rd_wen_i;
    end else if (ex_fire) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // WB slot: load on transfer from EX, else drain, else hold payload
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_reg  <= 1'b0;
      wb_uop_reg    <= '0;
      wb_res_reg    <= '0;
      wb_rs2_reg    <= '0;
      wb_rd_reg     <= '0;
      wb_rd_wen_reg <= 1'b0;
    end else if (ex_fire) begin
      wb_valid_reg  <= 1'b1;
      wb_uop_reg    <= ex_uop_reg;
      wb_res_reg    <= alu_res;
      wb_rs2_reg    <= ex_rs2_reg;
      wb_rd_reg     <= ex_rd_reg;
      wb_rd_wen_reg <= ex_rd_wen_eff;
    end else if (wb_fire) begin
      wb_valid_reg <= 1'b0;
    end
  end

  // Outputs read as zero while reset is held
  assign id_ready_o       = id_ready;
  assign redirect_valid_o = redirect_valid;
  assign redirect_pc_o    = rst_ni ? tgt_pc : '0;
  assign wb_valid_o       = rst_ni && wb_valid_reg;
  assign wb_uop_o         = rst_ni ? wb_uop_reg : '0;
  assign wb_res_o         = rst_ni ? wb_res_reg : '0;
  assign wb_rs2_o         = rst_ni ? wb_rs2_reg : '0;
  assign wb_rd_o          = rst_ni ? wb_rd_reg : '0;
  assign wb_rd_wen_o      = rst_ni && wb_rd_wen_reg;
endmodule
